queen_solution_collector: RTL

- Downstream consumer of the eight-queen solver controller/datapath.
- Captures the queen row index for each column as the solver's readout phase emits them, one per cycle.
- Re-checks the captured board for legality with a sequential pairwise checker, then streams the placement out over a valid/ready handshake.
- Propagates the solver's no-answer indication as a sticky status.

---
 rtl/queen_solution_collector.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/queen_solution_collector.sv
// Captures an eight-queen placement from the solver readout, re-checks it pairwise,
// then streams the board out over valid/ready with sticky legal/err/no_sol/dropped status.
module queen_solution_collector #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_col,
  input  logic [W-1:0] in_row,
  input  logic         in_last,
  input  logic         no_answer,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_col,
  output logic [W-1:0] out_row,
  output logic         out_last,
  output logic         busy,
  output logic         legal,
  output logic         err,
  output logic         no_sol,
  output logic         dropped
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [W-1:0] PEN_IDX  = W'(N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_STREAM,
    S_ERR,
    S_NOSOL
  } state_t;

  state_t       state, state_d;
  logic [W-1:0] rows [N];
  logic [N-1:0] mask;
  logic [N-1:0] col_hot;
  logic [N-1:0] mask_next;
  logic [W-1:0] pi, pj;
  logic [W-1:0] k;

  logic wr_en, chk_start, chk_adv, beat_adv, stream_done;
  logic set_err, set_legal, set_no_sol, set_dropped;

  // Pairwise checker: one (pi, pj) pair per cycle, only ever run on a full mask.
  logic [W-1:0] row_i, row_j, col_gap;
  logic [W:0]   row_diff, row_dist;
  logic         conflict;
  logic         last_pair;

  assign row_i     = rows[pi];
  assign row_j     = rows[pj];
  assign col_gap   = pj - pi;
  assign row_diff  = {1'b0, row_i} - {1'b0, row_j};
  assign row_dist  = row_diff[W] ? -row_diff : row_diff;
  assign conflict  = (row_i == row_j) || (row_dist == {1'b0, col_gap});
  assign last_pair = (pi == PEN_IDX) && (pj == LAST_IDX);

  assign col_hot   = N'(1) << in_col;
  assign mask_next = mask | col_hot;

  assign busy      = (state == S_COLLECT) || (state == S_CHECK) || (state == S_STREAM);
  assign out_valid = (state == S_STREAM);
  assign out_col   = out_valid ? k : '0;
  assign out_row   = out_valid ? rows[k] : '0;
  assign out_last  = out_valid && (k == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state;
    wr_en       = 1'b0;
    chk_start   = 1'b0;
    chk_adv     = 1'b0;
    beat_adv    = 1'b0;
    stream_done = 1'b0;
    set_err     = 1'b0;
    set_legal   = 1'b0;
    set_no_sol  = 1'b0;
    set_dropped = 1'b0;

    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_COLLECT: begin
          if (no_answer) begin
            set_no_sol = 1'b1;
            state_d    = S_NOSOL;
          end else if (in_valid) begin
            wr_en   = 1'b1;
            state_d = S_COLLECT;
            if (in_last) begin
              if (&mask_next) begin
                chk_start = 1'b1;
                state_d   = S_CHECK;
              end else begin
                set_err = 1'b1;
                state_d = S_ERR;
              end
            end
          end
        end
        S_CHECK: begin
          set_dropped = in_valid;
          if (conflict) begin
            set_err = 1'b1;
            state_d = S_ERR;
          end else if (last_pair) begin
            set_legal = 1'b1;
            state_d   = S_STREAM;
          end else begin
            chk_adv = 1'b1;
          end
        end
        S_STREAM: begin
          set_dropped = in_valid;
          if (out_ready) begin
            beat_adv = 1'b1;
            if (k == LAST_IDX) begin
              stream_done = 1'b1;
              state_d     = S_IDLE;
            end
          end
        end
        S_ERR, S_NOSOL: state_d = state;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the row store is small flop storage and reads out as zero after reset, so it is reset too.
      for (int i = 0; i < N; i++) rows[i] <= '0;
      mask    <= '0;
      pi      <= '0;
      pj      <= '0;
      k       <= '0;
      legal   <= 1'b0;
      err     <= 1'b0;
      no_sol  <= 1'b0;
      dropped <= 1'b0;
    end else if (clear) begin
      mask    <= '0;
      k       <= '0;
      legal   <= 1'b0;
      err     <= 1'b0;
      no_sol  <= 1'b0;
      dropped <= 1'b0;
    end else begin
      if (wr_en) begin
        rows[in_col] <= in_row;
        mask         <= mask_next;
        legal        <= 1'b0;
      end

      if (chk_start) begin
        pi <= '0;
        pj <= W'(1);
      end else if (chk_adv) begin
        if (pj == LAST_IDX) begin
          pi <= pi + W'(1);
          pj <= pi + W'(2);
        end else begin
          pj <= pj + W'(1);
        end
      end

      if (set_legal) begin
        legal <= 1'b1;
        k     <= '0;
      end else if (beat_adv) begin
        k <= stream_done ? '0 : k + W'(1);
      end

      if (stream_done) mask    <= '0;
      if (set_err)     err     <= 1'b1;
      if (set_no_sol)  no_sol  <= 1'b1;
      if (set_dropped) dropped <= 1'b1;
    end
  end

endmodule
